// File: rtl/bcd2_counter_scan.sv
// rtl/bcd2_counter_scan.sv - two-digit BCD up/down counter with load, terminal count and digit scanner
// Feeds a BCD-to-decimal decoder; every digit it can present is a legal BCD code.
module bcd2_counter_scan #(
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] q,
   output logic       tc,
   output logic       load_err,
   output logic [3:0] d_out,
   output logic [1:0] dig_sel
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

   logic [3:0]    ones_q, ones_d;
   logic [3:0]    tens_q, tens_d;
   logic          load_err_q, load_err_d;
   logic [1:0]    dig_sel_q, dig_sel_d;
   logic [CW-1:0] scan_cnt_q, scan_cnt_d;

   logic          ones_bad, tens_bad;
   logic          at_max, at_min;

   always_comb begin
      ones_bad = (load_val[3:0] > 4'd9);
      tens_bad = (load_val[7:4] > 4'd9);
      at_max   = (tens_q == 4'd9) && (ones_q == 4'd9);
      at_min   = (tens_q == 4'd0) && (ones_q == 4'd0);
   end

   // Load beats count; invalid load digits are forced to zero so q stays BCD.
   always_comb begin
      ones_d     = ones_q;
      tens_d     = tens_q;
      load_err_d = 1'b0;
      if (load) begin
         ones_d     = ones_bad ? 4'd0 : load_val[3:0];
         tens_d     = tens_bad ? 4'd0 : load_val[7:4];
         load_err_d = ones_bad | tens_bad;
      end else if (en) begin
         if (up) begin
            if (ones_q >= 4'd9) begin
               ones_d = 4'd0;
               tens_d = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end else begin
            if (ones_q == 4'd0) begin
               ones_d = 4'd9;
               tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end
      end
   end

   // The scanner free-runs regardless of counting or loading.
   always_comb begin
      scan_cnt_d = scan_cnt_q;
      dig_sel_d  = dig_sel_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_sel_d  = {dig_sel_q[0], dig_sel_q[1]};
      end else begin
         scan_cnt_d = scan_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         load_err_q <= 1'b0;
         dig_sel_q  <= 2'b01;
         scan_cnt_q <= '0;
      end else begin
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         load_err_q <= load_err_d;
         dig_sel_q  <= dig_sel_d;
         scan_cnt_q <= scan_cnt_d;
      end
   end

   always_comb begin
      q        = {tens_q, ones_q};
      load_err = load_err_q;
      dig_sel  = dig_sel_q;
      d_out    = dig_sel_q[1] ? tens_q : ones_q;
      tc       = en & ~load & ((up & at_max) | (~up & at_min));
   end

endmodule

// File: tb/tb_bcd2_counter_scan.sv
// tb/tb_bcd2_counter_scan.sv - scoreboard bench for bcd2_counter_scan
// Reference model keeps the count as an integer 0..99 and the scan phase as an edge count.
module tb_bcd2_counter_scan;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [7:0] q;
   logic       tc;
   logic       load_err;
   logic [3:0] d_out;
   logic [1:0] dig_sel;

   bcd2_counter_scan #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .q(q), .tc(tc), .load_err(load_err), .d_out(d_out), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   m_val = 0;
   logic exp_tc;
   int   edges = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   function automatic logic [1:0] exp_sel();
      return (((edges / SD) % 2) == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   function automatic logic [3:0] exp_digit(input logic [7:0] b);
      logic [1:0] s;
      s = exp_sel();
      return s[1] ? b[7:4] : b[3:0];
   endfunction

   task automatic drive(input logic e, input logic u, input logic l, input logic [7:0] lv);
      int   t, o;
      logic er;
      en = e; up = u; load = l; load_val = lv;
      exp_tc = e & ~l & ((u & (m_val == 99)) | (~u & (m_val == 0)));
      er = 1'b0;
      if (l) begin
         t = int'(lv[7:4]);
         o = int'(lv[3:0]);
         er = (t > 9) || (o > 9);
         m_val = ((t > 9) ? 0 : t) * 10 + ((o > 9) ? 0 : o);
      end else if (e) begin
         m_val = u ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end
      sb.push_back({to_bcd(m_val), er});
   endtask

   task automatic test_reset();
      #1;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: q=%h expected 00", q); end
      checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL rst_sel: dig_sel=%b expected 01", dig_sel); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rst_err: load_err=%b expected 0", load_err); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_tc: tc=%b expected 0", tc); end
      @(negedge clk); rst = 1'b0;
      for (int k = 1; k <= 4 * SD; k++) begin
         @(posedge clk); #1;
         checks++;
         if (dig_sel !== ((((k / SD) % 2) == 1) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL scan_sel edge %0d: dig_sel=%b expected %b", k, dig_sel,
                               (((k / SD) % 2) == 1) ? 2'b10 : 2'b01);
         end
         checks++; if (d_out !== 4'd0) begin errors++; $display("FAIL scan_dout edge %0d: d_out=%h expected 0", k, d_out); end
      end
   endtask

   task automatic test_up_wrap();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive(1'b0, 1'b0, 1'b1, 8'h97);
         else        drive(1'b1, 1'b1, 1'b0, 8'h00);
         #1;
         checks++; if (tc !== exp_tc) begin errors++; $display("FAIL up_tc step %0d: tc=%b expected %b", i, tc, exp_tc); end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++; if (q !== e.q) begin errors++; $display("FAIL up_q step %0d: q=%h expected %h", i, q, e.q); end
      end
   endtask

   task automatic test_down_borrow();
      exp_t e;
      for (int i = 0; i < 13; i++) begin
         if (i == 0) drive(1'b0, 1'b1, 1'b1, 8'h10);
         else        drive(1'b1, 1'b0, 1'b0, 8'h00);
         #1;
         checks++; if (tc !== exp_tc) begin errors++; $display("FAIL down_tc step %0d: tc=%b expected %b", i, tc, exp_tc); end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++; if (q !== e.q) begin errors++; $display("FAIL down_q step %0d: q=%h expected %h", i, q, e.q); end
      end
   endtask

   task automatic test_invalid_load();
      logic [7:0] vals [3];
      exp_t e;
      vals[0] = 8'h3C; vals[1] = 8'hF5; vals[2] = 8'h42;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) drive(1'b1, 1'b1, 1'b1, vals[i / 2]);
         else            drive(1'b0, 1'b1, 1'b0, 8'hFF);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++; if (q !== e.q) begin errors++; $display("FAIL inv_q step %0d: q=%h expected %h", i, q, e.q); end
         checks++; if (load_err !== e.err) begin errors++; $display("FAIL inv_err step %0d: load_err=%b expected %b", i, load_err, e.err); end
      end
   endtask

   task automatic test_priority();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) drive(1'b0, 1'b0, 1'b1, 8'h99);
         else        drive(1'b1, 1'b1, 1'b1, 8'h55);
         #1;
         checks++; if (tc !== exp_tc) begin errors++; $display("FAIL prio_tc step %0d: tc=%b expected %b", i, tc, exp_tc); end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++; if (q !== e.q) begin errors++; $display("FAIL prio_q step %0d: q=%h expected %h", i, q, e.q); end
      end
   endtask

   task automatic test_decoder();
      exp_t e;
      drive(1'b0, 1'b0, 1'b1, 8'h74);
      @(posedge clk); #1;
      e = sb.pop_front();
      for (int i = 0; i < 3 * SD; i++) begin
         checks++;
         if (d_out !== ((dig_sel == 2'b10) ? 4'd7 : 4'd4) || dig_sel !== exp_sel()) begin
            errors++; $display("FAIL dec_dout cycle %0d: d_out=%h sel=%b expected sel=%b d_out=%h",
                               i, d_out, dig_sel, exp_sel(), exp_digit(e.q));
         end
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         @(posedge clk); #1;
         e = sb.pop_front();
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b0, 1'b0, 1'b1, 8'h8F);
      @(posedge clk); #1;
      void'(sb.pop_front());
      load = 1'b0;
      #3 rst = 1'b1;
      #1;
      m_val = 0;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q: q=%h expected 00", q); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: load_err=%b expected 0", load_err); end
      checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL mid_rst_sel: dig_sel=%b expected 01", dig_sel); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_random();
      exp_t e;
      logic l;
      for (int i = 0; i < 150; i++) begin
         l = ($urandom_range(0, 5) == 0);
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), l, 8'($urandom_range(0, 255)));
         #1;
         checks++; if (tc !== exp_tc) begin errors++; $display("FAIL rnd_tc cycle %0d: tc=%b expected %b", i, tc, exp_tc); end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if (q !== e.q || load_err !== e.err) begin
            errors++; $display("FAIL rnd_q cycle %0d: q=%h err=%b expected q=%h err=%b", i, q, load_err, e.q, e.err);
         end
         checks++;
         if (d_out > 4'd9 || d_out !== exp_digit(e.q) || dig_sel !== exp_sel()) begin
            errors++; $display("FAIL rnd_dout cycle %0d: d_out=%h sel=%b expected d_out=%h sel=%b",
                               i, d_out, dig_sel, exp_digit(e.q), exp_sel());
         end
      end
   endtask

   initial begin
      #12;
      test_reset();
      test_up_wrap();
      test_down_borrow();
      test_invalid_load();
      test_priority();
      test_decoder();
      test_mid_reset();
      test_random();
      en = 1'b0; load = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd2_counter_scan.md
# bcd2_counter_scan

Two-digit BCD up/down counter with synchronous load, terminal-count output and a time-multiplexed digit scanner. It sits directly upstream of the BCD-to-decimal decoder. `d_out` drives the decoder's 4-bit BCD input. `dig_sel` selects which physical digit (ones or tens) the decoded one-hot pattern belongs to. `d_out` never carries a value above 9, so the decoder never sees an invalid code.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit is held on `d_out` before the scanner switches digit. Legal values are ≥ 1.
- `clk` in, 1 bit: clock, rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `en` in, 1 bit: count enable.
- `up` in, 1 bit: direction; 1 = increment, 0 = decrement.
- `load` in, 1 bit: synchronous load strobe.
- `load_val` in, 8 bits: load value; `[7:4]` = tens digit, `[3:0]` = ones digit.
- `q` out, 8 bits: registered count; `[7:4]` = tens, `[3:0]` = ones; always valid BCD.
- `tc` out, 1 bit: terminal count (combinational).
- `load_err` out, 1 bit: registered; one-cycle pulse when a load contained a non-BCD digit.
- `d_out` out, 4 bits: currently scanned digit (combinational from registers); feeds the decoder.
- `dig_sel` out, 2 bits: one-hot digit select; `01` = ones, `10` = tens.

## Operation
- **Reset** (`rst` = 1, asynchronous):
  - `q` = 0x00, `load_err` = 0, `dig_sel` = `01`, scan counter = 0.
  - Hence `d_out` = 0 and `tc` = 0.
- **Priority per edge:** `load` > `en` > hold.
- **Load** (`load` = 1):
  - Each digit of `load_val` is checked independently.
  - A valid digit (0–9) is loaded as-is.
  - An invalid digit (A–F) is loaded as 0.
  - `load_err` = 1 on the following cycle if either digit was invalid, else 0.
  - `en` and `up` are ignored during a load.
- **Count up** (`en` = 1, `load` = 0, `up` = 1):
  - Ones digit 0→9 increments.
  - Ones 9→0 carries +1 into tens.
  - 99 wraps to 00.
- **Count down** (`up` = 0):
  - Ones digit decrements.
  - Ones 0→9 borrows −1 from tens.
  - 00 wraps to 99.
- **Hold:** `en` = 0 and `load` = 0 → `q` holds.
- **`load_err`:** is 0 on every cycle without a load.
- **`tc`** = `en` & ~`load` & ((`up` & `q` == 0x99) | (~`up` & `q` == 0x00)). It marks the cycle whose edge produces the wrap.
- **Scanner:**
  - Runs continuously, independent of `en` and `load`.
  - Scan counter counts 0 … `SCAN_DIV`−1.
  - When it equals `SCAN_DIV`−1, it returns to 0 on that edge and `dig_sel` toggles `01` ↔ `10`.
  - Counter width is $clog2(`SCAN_DIV`), minimum 1 bit.
- **`d_out`** = `dig_sel[1]` ? `q[7:4]` : `q[3:0]`. A change in `q` appears on `d_out` in the same cycle if that digit is selected.

## Timing
- Load and count latency: one edge. The new `q` is visible after the edge where `load` or `en` was sampled high.
- `load_err` asserts after the same edge that captures the load, for exactly one cycle unless the next cycle loads another invalid value.
- `tc` is combinational from `q`, `en`, `up` and `load`; it has no latency.
- Scanner: after reset release, `dig_sel` = `01` for exactly `SCAN_DIV` rising edges, then `10` for `SCAN_DIV` edges, and so on.
- `SCAN_DIV` = 1: `dig_sel` toggles every edge.
- **Reset mid-operation:** all state returns to reset values immediately, without waiting for a clock edge. The first count, load or scan step happens on the first rising edge with `rst` = 0.
- **Simultaneous `load` + `en` at 0x99 with `up` = 1:** the load wins and `tc` = 0.
- `up` may change between any two cycles. Direction takes effect on the next enabled edge, with no extra latency.

## Test plan
- **Reset and scan:** assert `rst` mid-cycle, release, hold `en` = 0 with `SCAN_DIV` = 4.
  - During reset: `q` = 0x00 and `dig_sel` = `01` immediately.
  - After release: `dig_sel` = `01` for 4 edges, `10` for 4 edges, then repeats; `d_out` = 0 throughout.
- **Up count and wrap:** load 0x97, then `en` = 1, `up` = 1 for 3 cycles.
  - `q` sequence: 0x98, 0x99, 0x00.
  - `tc` = 1 only in the cycle while `q` = 0x99.
- **Down count and borrow:** load 0x10, then `en` = 1, `up` = 0 for 12 cycles.
  - `q` sequence: 0x09, 0x08, …, 0x00, 0x99, 0x98.
  - `tc` = 1 only while `q` = 0x00.
- **Invalid load:**
  - Load 0x3C → `q` = 0x30 and `load_err` pulses for 1 cycle.
  - Load 0xF5 → `q` = 0x05 and `load_err` pulses for 1 cycle.
  - Load 0x42 → `q` = 0x42 and `load_err` = 0.
- **Priority:** with `q` = 0x99, `en` = 1, `up` = 1, `load` = 1, `load_val` = 0x55 → `q` = 0x55 and `tc` = 0 in that cycle.
- **Decoder-facing check:** load 0x74, then sample while the scanner runs.
  - `d_out` = 4 while `dig_sel` = `01`, and `d_out` = 7 while `dig_sel` = `10`.
  - Randomised counting and loading shows `d_out` ≤ 9 on every cycle.
